// File: rtl/mux_rr_arb.sv
// mux_rr_arb: NCH-channel arbitrated multiplexer with valid/ready handshakes.
// One channel is granted per cycle, by round-robin (mode=0) or by fixed
// lowest-index priority (mode=1). The granted word is captured into a
// one-entry output register. A new word is accepted whenever that register
// is empty or is being drained in the same cycle.
module mux_rr_arb #(
    parameter int WIDTH = 32,
    parameter int NCH   = 4,
    parameter int SELW  = $clog2(NCH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mode,
    input  logic [NCH*WIDTH-1:0] in_data,
    input  logic [NCH-1:0]       in_valid,
    output logic [NCH-1:0]       in_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [SELW-1:0]      out_sel
);

    // Output register and round-robin pointer.
    logic [WIDTH-1:0] r_out_data;
    logic             r_out_valid;
    logic [SELW-1:0]  r_out_sel;
    logic [SELW-1:0]  r_ptr;

    // Arbitration results for the current cycle.
    logic             w_load_en;
    logic             w_gnt_any;
    logic [SELW-1:0]  w_gnt_idx;
    logic             w_xfer;
    logic [WIDTH-1:0] w_gnt_data;
    logic [SELW-1:0]  w_ptr_next;

    // The register can take a new word when it is empty or is being drained now.
    assign w_load_en = ~r_out_valid | out_ready;

    // Pick the first valid channel, scanning from ptr (round-robin) or from 0 (priority).
    always_comb begin
        int              pos;
        logic [SELW-1:0] ch;
        // NOTE: every variable gets a default before the loop, so no path
        // leaves it unassigned and no latch is inferred.
        w_gnt_any = 1'b0;
        w_gnt_idx = '0;
        pos       = 0;
        ch        = '0;
        for (int k = 0; k < NCH; k++) begin
            if (mode) begin
                pos = k;
            end else begin
                pos = int'(r_ptr) + k;
                if (pos >= NCH) begin
                    pos = pos - NCH;
                end
            end
            ch = SELW'(pos);
            // NOTE: blocking assignments here let a later iteration see that an
            // earlier one already claimed the grant.
            if (!w_gnt_any && in_valid[ch]) begin
                w_gnt_any = 1'b1;
                w_gnt_idx = ch;
            end
        end
    end

    // A transfer happens only if someone is valid, the register can load, and reset is low.
    assign w_xfer     = w_load_en & ~rst & w_gnt_any;
    assign w_gnt_data = in_data[w_gnt_idx*WIDTH +: WIDTH];
    assign w_ptr_next = (w_gnt_idx == SELW'(NCH - 1)) ? '0 : w_gnt_idx + 1'b1;

    // Raise ready only toward the granted channel, and only when it will be accepted.
    always_comb begin
        in_ready = '0;
        if (w_xfer) begin
            in_ready[w_gnt_idx] = 1'b1;
        end
    end

    // Load, drain or hold the output register, and advance the round-robin pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the data word is reset too, because reset must show
            // out_data=0 and a held word must be discarded, not delivered later.
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sel   <= '0;
            r_ptr       <= '0;
        end else if (w_load_en) begin
            if (w_gnt_any) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_gnt_data;
                r_out_sel   <= w_gnt_idx;
                if (!mode) begin
                    r_ptr <= w_ptr_next;
                end
            end else begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign out_sel   = r_out_sel;

endmodule
